datamem_dma: RTL and testbench
==============================

# datamem_dma

Block-transfer initiator that drives the single-port data memory's write/read interface. It copies a run of 16-bit words from one memory region to another, or optionally fills a region with a constant. It sits beside the core datapath on the memory bus and owns the bus while `busy` is high. It treats the memory as a combinational-read, posedge-write responder.

## Interface
Parameters:
- `AW`, 6: significant address bits (64 words)
- `DW`, 16: data width
- `LW`, 7: length field width (0..64 words)

Ports:
- `clk`  in  1  system clock, all logic on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `mode`  in  1  0 = copy, 1 = fill
- `src_addr`  in  AW  first source word (copy)
- `dst_addr`  in  AW  first destination word
- `len`  in  LW  word count; values >64 clamp to 64
- `fill_data`  in  DW  fill pattern
- `busy`  out  1  high in RD/WR states
- `done`  out  1  one-cycle completion pulse
- `mem_write`  out  1  to memory MemWrite
- `mem_addr`  out  16  to memory Address; bits [15:AW] always 0
- `mem_wdata`  out  DW  to memory WriteData
- `mem_rdata`  in  DW  from memory ReadData (combinational)

## Operation
- States: IDLE, RD, WR, DONE.
- Transitions:
  - IDLE: `start`=1 latches `mode`, `src_addr`, `dst_addr`, `len` and `fill_data` into shadow registers. Go to DONE if len=0, else RD (copy) or WR (fill).
  - RD: drive `mem_addr`=src pointer, capture `mem_rdata` into the word buffer at the edge, go to WR.
  - WR: drive `mem_addr`=dst pointer, `mem_write`=1, `mem_wdata`=buffer (copy) or shadow `fill_data` (fill). Increment pointers and decrement the remaining count. If remaining=1, go to DONE; else go to RD (copy) or WR (fill).
  - DONE: `done`=1 for one cycle, then IDLE.
- Pointers wrap modulo 2^AW (63 -> 0). Length counter is LW bits.
- Copy is ascending. With overlapping regions where dst is in (src, src+len), data is replicated; this is not guarded.
- `start` outside IDLE is ignored. Input changes after acceptance have no effect.
- All outputs are driven from registers/state only, with no combinational input-to-output path.
- Reset values: all outputs 0, state IDLE, pointers and buffer 0. Reset mid-transfer aborts immediately. Words already written stay written. A WR cycle in progress when reset asserts does not write.

## Timing
- `start` accepted at edge k.
- Copy of N≥1 words:
  - Word n is in RD during cycle k+1+2n and in WR during cycle k+2+2n.
  - `done` is high in cycle k+1+2N.
  - `busy` is high for cycles k+1 .. k+2N.
- Fill of N words: word n is in WR during cycle k+1+n; `done` is high in cycle k+1+N.
- len=0: `done` is high in cycle k+1, `busy` never rises, and no `mem_write`.
- Earliest next `start` acceptance: the edge ending the cycle after `done`.

## Configuration
- `DATAMEM_DMA_FILL_EN` defined: fill mode is available as described.
- `DATAMEM_DMA_FILL_EN` undefined:
  - `mode` is ignored and every transfer is a copy.
  - `fill_data` is unused and the shadow register is removed.
  - Ports are unchanged.

## Structure
- Shared package `datamem_dma_pkg`:
  - state enum (IDLE/RD/WR/DONE)
  - mode constants `MODE_COPY`=0 and `MODE_FILL`=1
  - default AW/DW/LW constants shared with the data memory
- Sub-module `datamem_dma_ptr`: AW-bit loadable, incrementing, wrapping pointer. Instantiated twice (src, dst).
- FSM and length counter live in the top.

## Test plan
- Memory preloaded with RAM[i]=0x1000+i; copy src=0, dst=32, len=4. Required:
  - RAM[32..35] = 0x1000..0x1003
  - `done` at k+9
  - exactly 4 `mem_write` cycles
- Fill dst=10, len=3, fill_data=0xBEEF. Required:
  - RAM[10..12] = 0xBEEF
  - RAM[13] unchanged
  - `done` at k+4
  - With the macro undefined, the same stimulus performs a copy from src instead.
- Copy src=62, dst=0, len=4. Required: reads 62, 63, 0, 1 and writes 0..3. RAM[0] gets old RAM[62]; RAM[2] gets the value written to RAM[0].
- len=0 start: `done` at k+1, `busy` stays 0, no write. len=100: exactly 64 words transferred.
- `start` pulsed during a transfer leaves the result and the `done` time unchanged. `rst_n` low during the second WR of a 4-word copy leaves only word 0 written, with all outputs 0 immediately. The next `start` after release works normally.

Source files
------------

// File: rtl/datamem_dma_pkg.sv
// Shared types and constants for the data-memory block-transfer engine.
package datamem_dma_pkg;
    localparam int DMA_AW = 6;
    localparam int DMA_DW = 16;
    localparam int DMA_LW = 7;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} dma_state_e;
endpackage

// File: rtl/datamem_dma_ptr.sv
// Loadable AW-bit address pointer that increments and wraps modulo 2^AW.
module datamem_dma_ptr
    import datamem_dma_pkg::*;
#(
    parameter int AW = DMA_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [AW-1:0] load_val_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);
    logic [AW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load_i)     ptr_d = load_val_i;
        else if (inc_i) ptr_d = ptr_q + AW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;
endmodule

// File: rtl/datamem_dma.sv
// Block copy / fill initiator for the single-port data memory.
// Fill mode is compiled in only when DATAMEM_DMA_FILL_EN is defined.
module datamem_dma
    import datamem_dma_pkg::*;
#(
    parameter int AW = DMA_AW,
    parameter int DW = DMA_DW,
    parameter int LW = DMA_LW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] fill_data,
    output logic          busy,
    output logic          done,
    output logic          mem_write,
    output logic [15:0]   mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam logic [LW-1:0] MAX_LEN = LW'(1 << AW);

    dma_state_e    state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] buf_q, buf_d;
    logic [LW-1:0] len_clamp;
    logic          accept, ptr_inc;
    logic          is_fill_in, is_fill_q;
    logic [AW-1:0] src_ptr, dst_ptr, addr_w;
    logic [DW-1:0] wdata_w;

    assign accept    = (state_q == IDLE) && start;
    assign len_clamp = (len > MAX_LEN) ? MAX_LEN : len;

`ifdef DATAMEM_DMA_FILL_EN
    logic          mode_q;
    logic [DW-1:0] fill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_COPY;
            fill_q <= '0;
        end else if (accept) begin
            mode_q <= mode;
            fill_q <= fill_data;
        end
    end

    assign is_fill_in = (mode == MODE_FILL);
    assign is_fill_q  = (mode_q == MODE_FILL);
    assign wdata_w    = is_fill_q ? fill_q : buf_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{mode, fill_data};
    assign is_fill_in = 1'b0;
    assign is_fill_q  = 1'b0;
    assign wdata_w    = buf_q;
`endif

    datamem_dma_ptr #(.AW(AW)) u_src_ptr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (src_addr),
        .inc_i      (ptr_inc),
        .ptr_o      (src_ptr)
    );

    datamem_dma_ptr #(.AW(AW)) u_dst_ptr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (dst_addr),
        .inc_i      (ptr_inc),
        .ptr_o      (dst_ptr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        ptr_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d = len_clamp;
                    if (len_clamp == '0) state_d = DONE;
                    else if (is_fill_in) state_d = WR;
                    else                 state_d = RD;
                end
            end
            RD: begin
                buf_d   = mem_rdata;
                state_d = WR;
            end
            WR: begin
                ptr_inc = 1'b1;
                cnt_d   = cnt_q - LW'(1);
                if (cnt_q == LW'(1)) state_d = DONE;
                else if (is_fill_q)  state_d = WR;
                else                 state_d = RD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    // Outputs decode registered state only; reset forces every one to 0.
    always_comb begin
        addr_w = '0;
        case (state_q)
            RD:      addr_w = src_ptr;
            WR:      addr_w = dst_ptr;
            default: addr_w = '0;
        endcase
    end

    assign busy      = (state_q == RD) || (state_q == WR);
    assign done      = (state_q == DONE);
    assign mem_write = (state_q == WR);
    assign mem_addr  = {{(16-AW){1'b0}}, addr_w};
    assign mem_wdata = wdata_w;
endmodule

// File: tb/tb_datamem_dma.sv
// Bench for datamem_dma: table of transfers scored against a memory model,
// plus hand sequences for spurious start and mid-transfer reset.
module tb_datamem_dma;
`ifdef DATAMEM_DMA_FILL_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, start, mode;
    logic [5:0]  src_addr, dst_addr;
    logic [6:0]  len;
    logic [15:0] fill_data;
    logic        busy, done, mem_write;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    datamem_dma dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
        .busy(busy), .done(done), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [15:0] ram [64];
    logic        ld_en;
    logic [5:0]  ld_addr;
    logic [15:0] ld_data;

    always @(posedge clk) begin
        if (ld_en)          ram[ld_addr] <= ld_data;
        else if (mem_write) ram[mem_addr[5:0]] <= mem_wdata;
    end
    assign mem_rdata = ram[mem_addr[5:0]];

    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    always @(negedge clk) if (mem_write) obs_q.push_back({mem_addr, mem_wdata});

    typedef struct {
        logic        mode;
        logic [5:0]  src;
        logic [5:0]  dst;
        logic [6:0]  len;
        logic [15:0] fill;
        int          lat;
        int          bsy;
    } vec_t;

    vec_t        vt[6];
    logic [15:0] exp_ram [64];
    int          nchk = 0;
    int          nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model(input vec_t v, input int nmax);
        int n;
        logic [5:0] a, s;
        logic [15:0] d;
        n = (v.len > 7'd64) ? 64 : int'(v.len);
        if (n > nmax) n = nmax;
        for (int i = 0; i < n; i++) begin
            a = v.dst + 6'(i);
            s = v.src + 6'(i);
            d = (v.mode && FE) ? v.fill : exp_ram[s];
            exp_ram[a] = d;
            exp_q.push_back({10'b0, a, d});
        end
    endtask

    task automatic launch(input vec_t v);
        @(negedge clk);
        start = 1'b1; mode = v.mode; src_addr = v.src; dst_addr = v.dst;
        len = v.len; fill_data = v.fill;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode = 1'($urandom); src_addr = 6'($urandom); dst_addr = 6'($urandom);
        len = 7'($urandom); fill_data = 16'($urandom);
    endtask

    task automatic run(input vec_t v, input bit spur, input string nm);
        int lat, bcnt;
        logic [31:0] o, e;
        obs_q.delete();
        exp_q.delete();
        model(v, 64);
        launch(v);
        lat = -1; bcnt = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin lat = c; break; end
            start = spur && (c == 2 || c == 3);
        end
        start = 1'b0;
        chk({nm, "_done_lat"}, lat, v.lat);
        chk({nm, "_busy_cycles"}, bcnt, v.bsy);
        chk({nm, "_nwrites"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({nm, "_write"}, o, e);
        end
    endtask

    initial begin
        vec_t v;
        int bad;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_data = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        vt[0] = '{1'b0, 6'd0,  6'd32, 7'd4,   16'h0000, 9, 8};
        vt[1] = '{1'b1, 6'd20, 6'd10, 7'd3,   16'hBEEF, FE ? 4 : 7, FE ? 3 : 6};
        vt[2] = '{1'b0, 6'd62, 6'd0,  7'd4,   16'h0000, 9, 8};
        vt[3] = '{1'b0, 6'd5,  6'd40, 7'd0,   16'h1234, 1, 0};
        vt[4] = '{1'b0, 6'd1,  6'd0,  7'd100, 16'h0000, 129, 128};
        vt[5] = '{1'b1, 6'd9,  6'd7,  7'd64,  16'h5A5A, FE ? 65 : 129, FE ? 64 : 128};

        @(negedge clk);
        ld_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            ld_addr = 6'(i);
            ld_data = 16'h1000 + 16'(i);
            exp_ram[i] = ld_data;
            @(posedge clk);
            #1;
        end
        ld_en = 1'b0;

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run(vt[i], 1'b0, $sformatf("vec%0d", i));
            if (i == 0) begin
                chk("copy_ram32", ram[32], 16'h1000);
                chk("copy_ram35", ram[35], 16'h1003);
            end
            if (i == 1) begin
                chk("fill_ram10", ram[10], FE ? 16'hBEEF : 16'h1014);
                chk("fill_ram12", ram[12], FE ? 16'hBEEF : 16'h1016);
                chk("fill_ram13", ram[13], 16'h100D);
            end
            if (i == 2) begin
                chk("wrap_ram0", ram[0], 16'h103E);
                chk("wrap_ram2", ram[2], 16'h103E);
                chk("wrap_ram3", ram[3], 16'h103F);
            end
        end

        v = '{1'b0, 6'd40, 6'd48, 7'd3, 16'h0, 7, 6};
        run(v, 1'b1, "spur_start");

        obs_q.delete();
        exp_q.delete();
        v = '{1'b0, 6'd16, 6'd50, 7'd4, 16'h0, 0, 0};
        model(v, 1);
        launch(v);
        for (int c = 1; c <= 3; c++) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_mem_write", mem_write, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_mem_wdata", mem_wdata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("abort_nwrites", obs_q.size(), 1);
        if (obs_q.size() > 0) chk("abort_write0", obs_q[0], exp_q[0]);
        chk("abort_ram50", ram[50], exp_ram[50]);
        chk("abort_ram51", ram[51], exp_ram[51]);

        v = '{1'b0, 6'd16, 6'd50, 7'd4, 16'h0, 9, 8};
        run(v, 1'b0, "post_reset");

        bad = 0;
        for (int i = 0; i < 64; i++) if (ram[i] !== exp_ram[i]) bad++;
        chk("ram_final_bad_words", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end
endmodule
